// File: rtl/bram_pkg.sv
// Shared types and helpers for the self-clearing single-port block RAM.
// Holds the sequencer state encoding, the error counter width and the byte-parity generator.
package bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int ERR_COUNT_WIDTH = 16;

  // Widest word the parity helper accepts; callers zero-extend and truncate with casts.
  localparam int MAX_DATA_WIDTH = 1024;

  // Even parity per byte: bit i makes byte i plus its parity bit hold an even number of ones.
  function automatic logic [MAX_DATA_WIDTH/8-1:0] byte_parity(
    input logic [MAX_DATA_WIDTH-1:0] word
  );
    logic [MAX_DATA_WIDTH/8-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_DATA_WIDTH / 8; i++) begin
      par[i] = ^word[i*8 +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Clear sequencer: after reset it walks every word address once, asserting a write
// strobe each cycle, then parks in READY and reports done.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    unique case (state_q)
      CLEAR: begin
        init_we_o = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign init_addr_o = cnt_q;
  assign done_o      = (state_q == READY);

endmodule

// File: rtl/bram_sp_init.sv
// Single-port byte-writable block RAM that clears itself to INIT_VALUE after every reset.
// Define BRAM_PARITY_EN to store per-byte even parity and flag/count read parity errors.
module bram_sp_init
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    BRAM_ADDR_WIDTH = 16,
  parameter int                    DEPTH           = 2 ** BRAM_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        bram_en,
  input  logic [DATA_WIDTH/8-1:0]     bram_we,
  input  logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
  input  logic [DATA_WIDTH-1:0]       bram_wrdata,
  output logic [DATA_WIDTH-1:0]       bram_rddata,
  output logic                        init_done,
  output logic                        err_valid,
  output logic [ERR_COUNT_WIDTH-1:0]  err_count
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AWP   = BRAM_ADDR_WIDTH + 1;
  // One extra bit so DEPTH == 2**BRAM_ADDR_WIDTH still compares correctly.
  localparam logic [AWP-1:0] DEPTH_A = AWP'(DEPTH);

  logic             init_we;
  logic [IDX_W-1:0] init_addr;
  logic             ready;

  bram_init_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (IDX_W)
  ) u_init_seq (
    .clk         (clk),
    .rstn        (rstn),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .done_o      (ready)
  );

  assign init_done = ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic                  port_fire;
  logic                  rd_fire;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rddata_q, rddata_d;

  // The clear sequencer owns the array while not ready; port requests are ignored then.
  always_comb begin
    in_range  = ({1'b0, bram_addr} < DEPTH_A);
    port_fire = ready & bram_en;
    rd_fire   = port_fire & in_range;
    idx       = init_we ? init_addr : bram_addr[IDX_W-1:0];
    wr_data   = init_we ? INIT_VALUE : bram_wrdata;
    wr_be     = '0;
    if (init_we) begin
      wr_be = '1;
    end else if (rd_fire) begin
      wr_be = bram_we;
    end
    rd_word  = mem[idx];
    rddata_d = rddata_q;
    if (port_fire) begin
      rddata_d = rd_fire ? rd_word : '0;
    end
  end

  // NOTE: the array has no reset; the clear sequencer gives it a known image instead.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read-first: rd_word is sampled before this edge's byte writes land.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rddata_q <= '0;
    end else begin
      rddata_q <= rddata_d;
    end
  end

  assign bram_rddata = rddata_q;

`ifdef BRAM_PARITY_EN
  logic [NB-1:0]              par_mem [DEPTH];
  logic [NB-1:0]              wr_par;
  logic [NB-1:0]              rd_par;
  logic                       err_d, err_valid_q;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;

  always_comb begin
    wr_par      = NB'(byte_parity(MAX_DATA_WIDTH'(wr_data)));
    rd_par      = NB'(byte_parity(MAX_DATA_WIDTH'(rd_word)));
    err_d       = rd_fire && (rd_par != par_mem[idx]);
    err_count_d = err_count_q;
    if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        par_mem[idx][b] <= wr_par[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_valid_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_count = err_count_q;
`else
  assign err_valid = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_bram_sp_init.sv
// Self-checking bench for bram_sp_init (DEPTH=16): directed clear/reset/access cases,
// then random traffic against an array model; parity cases when BRAM_PARITY_EN is defined.
module tb_bram_sp_init;

  localparam int DW    = 64;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          bram_en = 1'b0;
  logic [NB-1:0] bram_we = '0;
  logic [AW-1:0] bram_addr = '0;
  logic [DW-1:0] bram_wrdata = '0;
  logic [DW-1:0] bram_rddata;
  logic          init_done;
  logic          err_valid;
  logic [15:0]   err_count;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_rd;
  logic [15:0]   exp_err_count;

  always #5 clk = ~clk;

  bram_sp_init #(
    .DATA_WIDTH      (DW),
    .BRAM_ADDR_WIDTH (AW),
    .DEPTH           (DEPTH),
    .INIT_VALUE      ('0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wrdata (bram_wrdata),
    .bram_rddata (bram_rddata),
    .init_done   (init_done),
    .err_valid   (err_valid),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one request for one clock edge, then sample 1 time unit after that edge.
  task automatic drive(input logic en, input logic [NB-1:0] we, input int addr,
                       input logic [DW-1:0] d);
    bram_en     = en;
    bram_we     = we;
    bram_addr   = AW'(addr);
    bram_wrdata = d;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_done is seen; 0 means it never rose within the budget.
  task automatic wait_init(output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (init_done) begin
        edges = k;
        break;
      end
    end
  endtask

  // Ready-state access: the model predicts read data from the old contents, then merges bytes.
  task automatic access(input string tag, input logic en, input logic [NB-1:0] we,
                        input int addr, input logic [DW-1:0] d, input logic exp_err);
    if (en) begin
      if (addr < DEPTH) begin
        exp_rd = model[addr];
        for (int b = 0; b < NB; b++) begin
          if (we[b]) model[addr][b*8 +: 8] = d[b*8 +: 8];
        end
      end else begin
        exp_rd = '0;
      end
    end
    drive(en, we, addr, d);
    check({tag, "_rddata"}, bram_rddata, exp_rd);
    check({tag, "_err_valid"}, DW'(err_valid), DW'(exp_err));
    check({tag, "_err_count"}, DW'(err_count), DW'(exp_err_count));
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            edges;
    logic          r_en;
    logic [NB-1:0] r_we;
    int            r_addr;
    logic [DW-1:0] r_data;

    clear_model();
    exp_err_count = '0;

    // Reset state
    #12;
    check("rst_rddata", bram_rddata, '0);
    check("rst_init_done", DW'(init_done), '0);
    check("rst_err_valid", DW'(err_valid), '0);
    check("rst_err_count", DW'(err_count), '0);

    // Clear timing: init_done on exactly the 16th edge after release
    rstn = 1'b1;
    wait_init(edges);
    check("init_edges", DW'(edges), DW'(DEPTH));
    check("init_rddata", bram_rddata, '0);

    access("rd0",  1'b1, 8'h00, 0,  '0, 1'b0);
    access("rd7",  1'b1, 8'h00, 7,  '0, 1'b0);
    access("rd15", 1'b1, 8'h00, 15, '0, 1'b0);

    // Full-word write, then read back
    access("wr3", 1'b1, 8'hFF, 3, 64'h1122334455667788, 1'b0);
    access("rd3", 1'b1, 8'h00, 3, '0, 1'b0);
    check("rd3_const", bram_rddata, 64'h1122334455667788);

    // Partial write: low four bytes only
    access("wr5", 1'b1, 8'h0F, 5, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    access("rd5", 1'b1, 8'h00, 5, '0, 1'b0);
    check("rd5_const", bram_rddata, 64'h00000000FFFFFFFF);

    // Read-during-write returns old contents
    access("wr2a", 1'b1, 8'hFF, 2, 64'hA, 1'b0);
    access("rdw2", 1'b1, 8'hFF, 2, 64'hB, 1'b0);
    check("rdw2_old", bram_rddata, 64'hA);
    access("rd2b", 1'b1, 8'h00, 2, '0, 1'b0);
    check("rd2b_new", bram_rddata, 64'hB);

    // en low: output holds, write strobes ignored
    access("hold", 1'b0, 8'hFF, 2, 64'h5555, 1'b0);
    check("hold_const", bram_rddata, 64'hB);
    access("rd2c", 1'b1, 8'h00, 2, '0, 1'b0);
    check("rd2c_const", bram_rddata, 64'hB);

    // Out-of-range: write dropped (no alias onto addr 4), read returns 0
    access("rd3b", 1'b1, 8'h00, 3, '0, 1'b0);
    access("wr20", 1'b1, 8'hFF, 20, 64'hDEADBEEFCAFEF00D, 1'b0);
    check("wr20_rd0", bram_rddata, '0);
    access("rd4",  1'b1, 8'h00, 4, '0, 1'b0);
    check("rd4_noalias", bram_rddata, '0);
    access("rd3c", 1'b1, 8'h00, 3, '0, 1'b0);
    access("rd20", 1'b1, 8'h00, 20, '0, 1'b0);
    check("rd20_const", bram_rddata, '0);

    // Reset in READY, then requests during CLEAR and a reset at clear cycle 5
    rstn = 1'b0;
    #1;
    check("rst2_init_done", DW'(init_done), '0);
    check("rst2_rddata", bram_rddata, '0);
    #2;
    rstn = 1'b1;
    bram_en     = 1'b1;
    bram_we     = 8'hFF;
    bram_addr   = AW'(1);
    bram_wrdata = 64'hFFFFFFFFFFFFFFFF;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      check("clr_init_done", DW'(init_done), '0);
      check("clr_rddata", bram_rddata, '0);
    end
    rstn = 1'b0;
    #1;
    check("rst3_init_done", DW'(init_done), '0);
    #2;
    rstn = 1'b1;
    wait_init(edges);
    check("reinit_edges", DW'(edges), DW'(DEPTH));
    check("reinit_rddata", bram_rddata, '0);
    clear_model();
    access("rd1_after_clr", 1'b1, 8'h00, 1, '0, 1'b0);
    check("rd1_const", bram_rddata, '0);
    access("rd3_cleared", 1'b1, 8'h00, 3, '0, 1'b0);
    check("rd3_cleared_const", bram_rddata, '0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      r_en   = ($urandom_range(0, 3) != 0);
      r_we   = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      r_addr = int'($urandom_range(0, 19));
      r_data = {$urandom, $urandom};
      access("rand", r_en, r_we, r_addr, r_data, 1'b0);
    end

`ifdef BRAM_PARITY_EN
    // Corrupt a stored data bit behind the parity's back
    dut.mem[4][9] = ~dut.mem[4][9];
    model[4][9]   = ~model[4][9];
    exp_err_count = 16'd1;
    access("par_rd4", 1'b1, 8'h00, 4, '0, 1'b1);
    access("par_idle", 1'b0, 8'h00, 4, '0, 1'b0);
    access("par_rd3", 1'b1, 8'h00, 3, '0, 1'b0);
    dut.err_count_q = 16'hFFFF;
    exp_err_count   = 16'hFFFF;
    access("par_sat", 1'b1, 8'h00, 4, '0, 1'b1);
    access("par_sat2", 1'b1, 8'h00, 4, '0, 1'b1);
    access("par_fix", 1'b1, 8'hFF, 4, 64'h0123456789ABCDEF, 1'b1);
    access("par_ok", 1'b1, 8'h00, 4, '0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
